// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file for the five-stage
// pipeline. One write port (write-back stage), two independent
// combinational read ports (decode stage). r0 is hard-wired to zero.
//
// Optional feature macro: REGFILE_WB_BYPASS_EN
//   defined   : a read of the register being written in the same cycle
//               returns the incoming write data (write-to-read bypass).
//   undefined : such a read returns the stored (pre-write) value; the new
//               value becomes visible from the next cycle.
//
// Reset is synchronous and active-high. While reset is high both read
// ports return zero, and the reset edge clears every entry (a write
// presented in the same cycle is dropped).
module regfile (
   input  logic        clock,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic        re1,
   input  logic [4:0]  raddr1,
   output logic [31:0] rdata1,
   input  logic        re2,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata2
);

   localparam int unsigned REG_NUM = 32;
   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

   // Register storage. Entry 0 is written only with zero, so it folds
   // away to a constant in synthesis.
   logic [31:0] regs_q [REG_NUM];
   logic [31:0] regs_d [REG_NUM];

   // A write only lands when not in reset and not aimed at r0.
   logic write_ok;
   assign write_ok = we && (waddr != 5'd0);

   // Next-state for the array: reset clears everything, otherwise a
   // qualified write updates a single entry.
   always_comb begin
      regs_d = regs_q;
      if (reset) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_d[i] = ZERO_WORD;
         end
      end else if (write_ok) begin
         regs_d[waddr] = wdata;
      end
   end

   // Storage update on the rising clock edge.
   always_ff @(posedge clock) begin
      regs_q <= regs_d;
   end

   // One read port in priority order: reset, enable, r0, bypass, array.
   function automatic logic [31:0] read_port(
      input logic        rst,
      input logic        re,
      input logic [4:0]  raddr,
      input logic        wr_ok,
      input logic [4:0]  wr_addr,
      input logic [31:0] wr_data,
      input logic [31:0] stored
   );
      logic [31:0] value;
      value = stored;
      if (rst) begin
         value = ZERO_WORD;
      end else if (!re) begin
         value = ZERO_WORD;
      end else if (raddr == 5'd0) begin
         value = ZERO_WORD;
`ifdef REGFILE_WB_BYPASS_EN
      end else if (wr_ok && (wr_addr == raddr)) begin
         value = wr_data;
`endif
      end else begin
         value = stored;
      end
`ifndef REGFILE_WB_BYPASS_EN
      // Without the bypass the write-side inputs do not affect reads.
      if (wr_ok && (wr_addr == raddr) && (wr_data == stored)) begin
         value = value;
      end
`endif
      return value;
   endfunction

   // Read port 1: purely combinational from reset/enable/address.
   always_comb begin
      rdata1 = read_port(reset, re1, raddr1, write_ok, waddr, wdata,
                         regs_q[raddr1]);
   end

   // Read port 2: identical to port 1 and fully independent of it.
   always_comb begin
      rdata2 = read_port(reset, re2, raddr2, write_ok, waddr, wdata,
                         regs_q[raddr2]);
   end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and randomised checks of regfile. Expected read
// data is pushed to a scoreboard queue when each step is driven and
// popped and compared on the falling edge of the same cycle.
module tb_regfile;

   localparam bit BYP =
`ifdef REGFILE_WB_BYPASS_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clock;
   logic        reset;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        re1;
   logic [4:0]  raddr1;
   logic [31:0] rdata1;
   logic        re2;
   logic [4:0]  raddr2;
   logic [31:0] rdata2;

   int tests_run = 0;
   int tests_failed = 0;

   logic [63:0] exp_q [$];
   string       tag_q [$];
   logic [31:0] mdl [32];

   regfile dut (
      .clock  (clock),
      .reset  (reset),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .re1    (re1),
      .raddr1 (raddr1),
      .rdata1 (rdata1),
      .re2    (re2),
      .raddr2 (raddr2),
      .rdata2 (rdata2)
   );

   // Clock and reset-time defaults.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference read for the random phase.
   function automatic logic [31:0] model_read(
      input logic r, input logic [4:0] a,
      input logic w, input logic [4:0] wa, input logic [31:0] wd
   );
      if (!r || a == 5'd0) return 32'h0;
      if (BYP && w && wa == a) return wd;
      return mdl[a];
   endfunction

   // Drive one cycle, queue its expected reads, compare at the falling
   // edge, then advance past the rising edge and update the model.
   task automatic step(
      input logic rst, input logic w, input logic [4:0] wa,
      input logic [31:0] wd,
      input logic r1, input logic [4:0] a1,
      input logic r2, input logic [4:0] a2,
      input logic [31:0] e1, input logic [31:0] e2, input string tag
   );
      logic [63:0] e;
      string       t;
      reset  = rst;
      we     = w;
      waddr  = wa;
      wdata  = wd;
      re1    = r1;
      raddr1 = a1;
      re2    = r2;
      raddr2 = a2;
      exp_q.push_back({e1, e2});
      tag_q.push_back(tag);
      @(negedge clock);
      if (exp_q.size() == 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL scoreboard_empty got 0 entries exp 1");
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         tests_run++;
         assert (rdata1 === e[63:32]) else begin
            tests_failed++;
            $error("FAIL %s rdata1 got %h exp %h", t, rdata1, e[63:32]);
         end
         tests_run++;
         assert (rdata2 === e[31:0]) else begin
            tests_failed++;
            $error("FAIL %s rdata2 got %h exp %h", t, rdata2, e[31:0]);
         end
      end
      @(posedge clock);
      #1;
      if (rst) begin
         for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      end else if (w && wa != 5'd0) begin
         mdl[wa] = wd;
      end
   endtask

   initial begin
      logic        rw;
      logic [4:0]  rwa;
      logic [31:0] rwd;
      logic        rr1;
      logic        rr2;
      logic [4:0]  ra1;
      logic [4:0]  ra2;

      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

      // Reset holds outputs at zero even with enables up.
      step(1, 0, 0, 0, 1, 5, 1, 5, 32'h0, 32'h0, "reset_hold");
      // Reset clear: write r5, read back, reset, read again.
      step(0, 1, 5, 32'h1234_5678, 1, 5, 1, 5,
           BYP ? 32'h1234_5678 : 32'h0, BYP ? 32'h1234_5678 : 32'h0, "wr_r5");
      step(0, 0, 0, 0, 1, 5, 1, 5, 32'h1234_5678, 32'h1234_5678, "rd_r5");
      step(1, 0, 0, 0, 1, 5, 1, 5, 32'h0, 32'h0, "reset_during");
      step(0, 0, 0, 0, 1, 5, 1, 5, 32'h0, 32'h0, "reset_after");
      // Basic write/read at both ends of the address range.
      step(0, 1, 1, 32'hDEAD_BEEF, 1, 1, 1, 31,
           BYP ? 32'hDEAD_BEEF : 32'h0, 32'h0, "wr_r1");
      step(0, 1, 31, 32'h0000_0001, 1, 1, 1, 31,
           32'hDEAD_BEEF, BYP ? 32'h1 : 32'h0, "wr_r31");
      step(0, 0, 0, 0, 1, 1, 1, 31, 32'hDEAD_BEEF, 32'h1, "basic");
      // r0 protection in the write cycle and after.
      step(0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 32'h0, 32'h0, "r0_same");
      step(0, 0, 0, 0, 1, 0, 1, 0, 32'h0, 32'h0, "r0_next");
      // Read enable gating.
      step(0, 1, 7, 32'hAAAA_5555, 0, 7, 0, 7, 32'h0, 32'h0, "wr_r7");
      step(0, 0, 0, 0, 0, 7, 1, 7, 32'h0, 32'hAAAA_5555, "re1_low");
      step(0, 0, 0, 0, 1, 7, 0, 7, 32'hAAAA_5555, 32'h0, "re1_high");
      // Same-cycle write/read of r9.
      step(0, 1, 9, 32'h1111_1111, 1, 1, 1, 31, 32'hDEAD_BEEF, 32'h1, "wr_r9");
      step(0, 1, 9, 32'h2222_2222, 1, 9, 1, 9,
           BYP ? 32'h2222_2222 : 32'h1111_1111,
           BYP ? 32'h2222_2222 : 32'h1111_1111, "bypass");
      step(0, 0, 0, 0, 1, 9, 1, 9, 32'h2222_2222, 32'h2222_2222, "bypass_next");
      // Back-to-back writes to one address: last edge wins.
      step(0, 1, 4, 32'h0000_00A4, 1, 4, 1, 9,
           BYP ? 32'hA4 : 32'h0, 32'h2222_2222, "b2b_1");
      step(0, 1, 4, 32'h0000_00B4, 1, 4, 1, 4,
           BYP ? 32'hB4 : 32'hA4, BYP ? 32'hB4 : 32'hA4, "b2b_2");
      step(0, 0, 0, 0, 1, 4, 1, 4, 32'hB4, 32'hB4, "b2b_last");
      // Reset versus write on the same edge: reset wins.
      step(1, 1, 3, 32'h0BAD_F00D, 1, 3, 1, 3, 32'h0, 32'h0, "rst_wr_same");
      step(0, 0, 0, 0, 1, 3, 1, 9, 32'h0, 32'h0, "rst_wr_after");

      // Random mix of writes and reads against the reference model.
      for (int n = 0; n < 60; n++) begin
         rw  = ($urandom_range(0, 3) != 0);
         rwa = 5'($urandom_range(0, 31));
         rwd = $urandom;
         rr1 = ($urandom_range(0, 7) != 0);
         rr2 = ($urandom_range(0, 7) != 0);
         ra1 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom_range(0, 31));
         ra2 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom_range(0, 31));
         step(0, rw, rwa, rwd, rr1, ra1, rr2, ra2,
              model_read(rr1, ra1, rw, rwa, rwd),
              model_read(rr2, ra2, rw, rwa, rwd), "random");
      end

      // Sweep every register on both ports after the random phase.
      for (int a = 0; a < 32; a++) begin
         step(0, 0, 0, 0, 1, 5'(a), 1, 5'(31 - a),
              model_read(1, 5'(a), 0, 0, 0),
              model_read(1, 5'(31 - a), 0, 0, 0), "sweep");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
